update_serializer: RTL and testbench
====================================

UPDATE_SERIALIZER -- requirements
Module: update_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of vertex ID and update value.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, the number of storage entries (power of 2, >=8).
REQ-003 SHALL have parameter SKID, default 3, the number of upstream in-flight cycles to absorb (matches the combine stage PIPE_DEPTH).
REQ-004 SHALL have ports: clk  in  1  clock, all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 InputValid_A / InputValid_B  in  1  lane A / lane B update valid.
REQ-007 InDestVid_A / InDestVid_B  in  DATA_W  lane destination vertex ID.
REQ-008 InUpdate_A / InUpdate_B  in  DATA_W  lane update value.
REQ-009 InStall  out  1  throttle request to upstream, registered.
REQ-010 OutValid  out  1  single-lane output update valid.
REQ-011 OutReady  in  1  downstream accepts the output this cycle.
REQ-012 OutDestVid / OutUpdate  out  DATA_W  output destination vertex ID / update value.
REQ-013 Count  out  clog2(FIFO_DEPTH)+1  entries held, storage plus output register.
REQ-014 Overflow  out  1  sticky flag: an input was dropped.

Function
REQ-015 SHALL accept up to two updates per cycle and emit at most one per cycle, preserving arrival order; when both lanes are valid, A is ordered before B.
REQ-016 Output SHALL be a first-word-fall-through register: an update written into an empty block SHALL appear with OutValid=1 on the next cycle (1-cycle latency).
REQ-017 A transfer SHALL occur on OutValid&&OutReady; OutDestVid/OutUpdate SHALL remain stable while OutValid=1 and OutReady=0.
REQ-018 Free space SHALL be computed as FIFO_DEPTH+1-Count, plus 1 if a transfer occurs that cycle (push and pop in the same cycle are legal at full).
REQ-019 If the incoming writes exceed the free space, the excess SHALL be dropped (B before A), and Overflow SHALL be set and held until reset.
REQ-020 InStall SHALL be 1 when free space < 2*(SKID+1), evaluated on the post-update Count, and 0 otherwise.
REQ-021 Storage pointers SHALL wrap modulo FIFO_DEPTH; Count SHALL never exceed FIFO_DEPTH+1.
REQ-022 Input lanes with InputValid=0 SHALL be ignored regardless of the data values present on them.

Reset
REQ-023 While rst=0, OutValid, InStall, Count and Overflow SHALL be 0, OutDestVid and OutUpdate SHALL be 0, and both pointers SHALL be 0, asynchronously.
REQ-024 Reset asserted mid-operation SHALL discard all held entries; the first input after rst rises SHALL be treated as arriving at an empty block.

Configuration
REQ-025 With macro UPD_COALESCE_EN defined, lanes A and B valid in the same cycle with equal DestVid SHALL be written as one entry carrying InUpdate_A+InUpdate_B, with the sum modulo 2^DATA_W.
REQ-026 With UPD_COALESCE_EN defined, an incoming update whose DestVid equals the newest entry still in storage (not in the output register) SHALL be added into that entry and SHALL consume no new slot.
REQ-027 With UPD_COALESCE_EN undefined, every valid lane SHALL occupy its own entry and no arithmetic is performed.

Structure
REQ-028 A shared package SHALL hold the update record typedef (dest_vid, update) and the default DATA_W.
REQ-029 Storage SHALL be one sub-module, upd_fifo_2w1r: a 2-write/1-read circular buffer; the output register, coalescing logic and flags SHALL sit in the top level.

Verification
REQ-030 Reset release, then A=(0x2E,1) only -> next cycle OutValid=1, OutDestVid=0x2E, OutUpdate=1, Count=1.
REQ-031 A=(0x1F,1), B=(0x1E,2) in one cycle, OutReady=1 -> outputs (0x1F,1) then (0x1E,2) on consecutive cycles.
REQ-032 OutReady=0, two updates per cycle until InStall=1 -> InStall asserts at free space <8; continuing to full -> Overflow=1, Count=17, and no entry is corrupted.
REQ-033 UPD_COALESCE_EN, A=(0x2E,1), B=(0x2E,4) -> single output (0x2E,5); without the macro -> two outputs (0x2E,1) then (0x2E,4).
REQ-034 UPD_COALESCE_EN, A=(0x2E,0xFFFFFFFF), B=(0x2E,2) -> output (0x2E,1) (wrap-around).
REQ-035 Count=9, rst pulsed low -> all outputs are 0 immediately; after release, A=(0x10,7) -> next cycle output (0x10,7).

Source files
------------

// File: rtl/update_serializer_pkg.sv
// rtl/update_serializer_pkg.sv - shared types and defaults for the update serializer
//
// Purpose : default data width and the update record carried through the
//           serializer (destination vertex ID plus update value).
// Ports   : none (package).
package update_serializer_pkg;

    localparam int DEFAULT_DATA_W = 32;

    typedef struct packed {
        logic [DEFAULT_DATA_W-1:0] dest_vid;
        logic [DEFAULT_DATA_W-1:0] update;
    } upd_rec_t;

endpackage

// File: rtl/update_serializer_if.sv
// rtl/update_serializer_if.sv - dual-lane input / single-lane output bundle for update_serializer
//
// Purpose : groups the upstream lanes, the throttle, the output handshake and
//           the status outputs of the serializer.
// Ports   : master - the environment (drives lanes and OutReady)
//           slave  - the serializer (drives InStall, Out*, Count, Overflow)
interface update_serializer_if
    import update_serializer_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 16
);
    logic                        InputValid_A;
    logic                        InputValid_B;
    logic [DATA_W-1:0]           InDestVid_A;
    logic [DATA_W-1:0]           InDestVid_B;
    logic [DATA_W-1:0]           InUpdate_A;
    logic [DATA_W-1:0]           InUpdate_B;
    logic                        InStall;
    logic                        OutValid;
    logic                        OutReady;
    logic [DATA_W-1:0]           OutDestVid;
    logic [DATA_W-1:0]           OutUpdate;
    logic [$clog2(FIFO_DEPTH):0] Count;
    logic                        Overflow;

    modport master (
        output InputValid_A, InputValid_B, InDestVid_A, InDestVid_B,
        output InUpdate_A, InUpdate_B, OutReady,
        input  InStall, OutValid, OutDestVid, OutUpdate, Count, Overflow
    );

    modport slave (
        input  InputValid_A, InputValid_B, InDestVid_A, InDestVid_B,
        input  InUpdate_A, InUpdate_B, OutReady,
        output InStall, OutValid, OutDestVid, OutUpdate, Count, Overflow
    );

endinterface

// File: rtl/update_serializer_fifo_2w1r.sv
// rtl/update_serializer_fifo_2w1r.sv - 2-write / 1-read circular buffer (module upd_fifo_2w1r)
//
// Purpose : circular storage accepting up to two records per cycle (port 0
//           is always the older one) and releasing one per cycle from the
//           head. A modify port rewrites the newest stored record in place.
// Ports   : clk, rst_n          clock, asynchronous active-low reset
//           i_wr0_en/i_wr0_data first write (older record)
//           i_wr1_en/i_wr1_data second write, only together with i_wr0_en
//           i_rd_en/o_rd_data   head pop / head record (combinational)
//           i_mod_en/i_mod_data rewrite of the newest record
//           o_tail_data         newest record
//           o_cnt               records held (0..DEPTH)
module upd_fifo_2w1r
    import update_serializer_pkg::*;
#(
    parameter int W     = 2 * DEFAULT_DATA_W,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_wr0_en,
    input  logic [W-1:0]            i_wr0_data,
    input  logic                    i_wr1_en,
    input  logic [W-1:0]            i_wr1_data,
    input  logic                    i_rd_en,
    output logic [W-1:0]            o_rd_data,
    input  logic                    i_mod_en,
    input  logic [W-1:0]            i_mod_data,
    output logic [W-1:0]            o_tail_data,
    output logic [$clog2(DEPTH):0]  o_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;

    logic [PTR_W-1:0] w_wr_ptr1;
    logic [PTR_W-1:0] w_tail_ptr;
    logic [1:0]       w_nwr;

    // Pointers are exactly PTR_W bits, so increments wrap modulo DEPTH.
    assign w_wr_ptr1   = r_wr_ptr + 1'b1;
    assign w_tail_ptr  = r_wr_ptr - 1'b1;
    assign w_nwr       = {1'b0, i_wr0_en} + {1'b0, i_wr1_en};
    assign o_rd_data   = r_mem[r_rd_ptr];
    assign o_tail_data = r_mem[w_tail_ptr];
    assign o_cnt       = r_cnt;

    always_ff @(posedge clk) begin
        if (i_wr0_en) begin
            r_mem[r_wr_ptr] <= i_wr0_data;
        end
        if (i_wr1_en) begin
            r_mem[w_wr_ptr1] <= i_wr1_data;
        end
        if (i_mod_en) begin
            r_mem[w_tail_ptr] <= i_mod_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_nwr);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_rd_en);
            r_cnt    <= r_cnt + CNT_W'(w_nwr) - CNT_W'(i_rd_en);
        end
    end

endmodule

// File: rtl/update_serializer.sv
// rtl/update_serializer.sv - two-lane to one-lane update serializer with FWFT output
//
// Purpose : accepts up to two vertex updates per cycle (lane A ahead of
//           lane B), stores them in order and emits one per cycle through a
//           first-word-fall-through output register. Writes beyond the free
//           space are dropped (B first) and flagged in a sticky Overflow.
//           InStall throttles upstream while fewer than 2*(SKID+1) slots
//           remain free.
// Ports   : clk  clock, rising edge
//           rst  asynchronous active-low reset
//           bus  update_serializer_if.slave (lanes, InStall, output
//                handshake, Count, Overflow)
// Config  : UPD_COALESCE_EN - merge equal-DestVid lanes of one cycle, and
//           merge an update into the newest stored entry with the same
//           DestVid (modulo-2^DATA_W sum).
module update_serializer
    import update_serializer_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 16,
    parameter int SKID       = 3
) (
    input  logic                clk,
    input  logic                rst,
    update_serializer_if.slave  bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] CAP      = (CNT_W+1)'(FIFO_DEPTH + 1);
    localparam logic [CNT_W:0] STALL_TH = (CNT_W+1)'(2 * (SKID + 1));

    typedef struct packed {
        logic [DATA_W-1:0] dest_vid;
        logic [DATA_W-1:0] update;
    } rec_t;

    rec_t             r_out;
    logic             r_out_valid;
    logic             r_stall;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;

    rec_t             w_in_a, w_in_b, w_e0, w_e1, w_head, w_tail, w_mod_data;
    rec_t             w_wr0_data, w_wr1_data, w_out_next;
    logic             w_e0_v, w_e1_v, w_acc0, w_acc1, w_drop;
    logic             w_pop, w_slot_free, w_fifo_nempty, w_rd_en, w_mod_en;
    logic             w_wr0_en, w_wr1_en, w_load_out;
    logic [CNT_W-1:0] w_fifo_cnt, w_count_next;
    logic [CNT_W:0]   w_free, w_free_next;

    assign w_in_a        = {bus.InDestVid_A, bus.InUpdate_A};
    assign w_in_b        = {bus.InDestVid_B, bus.InUpdate_B};
    assign w_pop         = r_out_valid & bus.OutReady;
    // Output register can take a record this cycle (empty, or being emptied).
    assign w_slot_free   = ~r_out_valid | w_pop;
    assign w_fifo_nempty = (w_fifo_cnt != '0);
    // FWFT: storage is only non-empty while the output register is full,
    // so the head moves up whenever the register frees.
    assign w_rd_en       = w_slot_free & w_fifo_nempty;

    // Ordered list of at most two new entries after coalescing.
    always_comb begin
        w_e0       = bus.InputValid_A ? w_in_a : w_in_b;
        w_e0_v     = bus.InputValid_A | bus.InputValid_B;
        w_e1       = w_in_b;
        w_e1_v     = bus.InputValid_A & bus.InputValid_B;
        w_mod_en   = 1'b0;
        w_mod_data = w_tail;
`ifdef UPD_COALESCE_EN
        if (w_e1_v && (w_in_a.dest_vid == w_in_b.dest_vid)) begin
            w_e0.update = w_in_a.update + w_in_b.update;
            w_e1_v      = 1'b0;
        end
        // Skip the merge when the newest entry is also the head leaving
        // storage this cycle; it is no longer "in storage" after the edge.
        // A surviving e1 always differs from e0, so only e0 can match.
        if (w_e0_v && w_fifo_nempty && !(w_rd_en && (w_fifo_cnt == CNT_W'(1)))
                && (w_e0.dest_vid == w_tail.dest_vid)) begin
            w_mod_en          = 1'b1;
            w_mod_data.update = w_tail.update + w_e0.update;
            w_e0              = w_e1;
            w_e0_v            = w_e1_v;
            w_e1_v            = 1'b0;
        end
`endif
    end

    assign w_free       = CAP - {1'b0, r_count} + (CNT_W+1)'(w_pop);
    // The later entry is the first to be dropped.
    assign w_acc0       = w_e0_v & (w_free != '0);
    assign w_acc1       = w_e1_v & (w_free > (CNT_W+1)'(1));
    assign w_drop       = (w_e0_v & ~w_acc0) | (w_e1_v & ~w_acc1);
    assign w_count_next = r_count - CNT_W'(w_pop) + CNT_W'(w_acc0) + CNT_W'(w_acc1);
    assign w_free_next  = CAP - {1'b0, w_count_next};

    // Route accepted entries: output register first when it frees and
    // storage is empty, everything else appended to storage in order.
    always_comb begin
        w_load_out = 1'b0;
        w_out_next = r_out;
        w_wr0_en   = 1'b0;
        w_wr0_data = w_e0;
        w_wr1_en   = 1'b0;
        w_wr1_data = w_e1;
        if (w_slot_free) begin
            if (w_fifo_nempty) begin
                w_load_out = 1'b1;
                w_out_next = w_head;
                w_wr0_en   = w_acc0;
                w_wr1_en   = w_acc1;
            end else if (w_acc0) begin
                w_load_out = 1'b1;
                w_out_next = w_e0;
                w_wr0_en   = w_acc1;
                w_wr0_data = w_e1;
            end
        end else begin
            w_wr0_en = w_acc0;
            w_wr1_en = w_acc1;
        end
    end

    upd_fifo_2w1r #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst),
        .i_wr0_en    (w_wr0_en),
        .i_wr0_data  (w_wr0_data),
        .i_wr1_en    (w_wr1_en),
        .i_wr1_data  (w_wr1_data),
        .i_rd_en     (w_rd_en),
        .o_rd_data   (w_head),
        .i_mod_en    (w_mod_en),
        .i_mod_data  (w_mod_data),
        .o_tail_data (w_tail),
        .o_cnt       (w_fifo_cnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_stall     <= 1'b0;
            r_overflow  <= 1'b0;
            r_count     <= '0;
        end else begin
            if (w_load_out) begin
                r_out       <= w_out_next;
                r_out_valid <= 1'b1;
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
            r_count <= w_count_next;
            r_stall <= (w_free_next < STALL_TH);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.OutValid   = r_out_valid;
    assign bus.OutDestVid = r_out.dest_vid;
    assign bus.OutUpdate  = r_out.update;
    assign bus.InStall    = r_stall;
    assign bus.Count      = r_count;
    assign bus.Overflow   = r_overflow;

endmodule

// File: tb/tb_update_serializer.sv
// tb/tb_update_serializer.sv - directed scoreboard bench for update_serializer
module tb_update_serializer;
    import update_serializer_pkg::*;

    localparam int DW    = DEFAULT_DATA_W;
    localparam int DEPTH = 16;
    localparam int SKID  = 3;
`ifdef UPD_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    update_serializer_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

    update_serializer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .SKID       (SKID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    upd_rec_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [DW-1:0] d, input logic [DW-1:0] u);
        sb.push_back({d, u});
    endtask

    task automatic drive(input logic va, input logic [DW-1:0] da, input logic [DW-1:0] ua,
                         input logic vb, input logic [DW-1:0] db, input logic [DW-1:0] ub);
        bus.InputValid_A = va;
        bus.InDestVid_A  = da;
        bus.InUpdate_A   = ua;
        bus.InputValid_B = vb;
        bus.InDestVid_B  = db;
        bus.InUpdate_B   = ub;
    endtask

    // Invalid lanes carry random data that must be ignored.
    task automatic idle();
        drive(1'b0, $urandom, $urandom, 1'b0, $urandom, $urandom);
    endtask

    // Sample at the falling edge; a transfer there happens at the next rise.
    task automatic tick();
        upd_rec_t e;
        @(negedge clk);
        if (bus.OutValid && bus.OutReady) begin
            chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_rec", {bus.OutDestVid, bus.OutUpdate}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        bus.OutReady = 1'b1;
        idle();
        for (int i = 0; i < 40 && (sb.size() != 0 || bus.OutValid); i++) begin
            tick();
        end
        chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
        chk({tag, "_count0"}, 64'(bus.Count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt_m;
        int acc;
        bus.OutReady = 1'b0;
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.OutValid), 64'd0);
        chk("rst_stall", 64'(bus.InStall), 64'd0);
        chk("rst_count", 64'(bus.Count), 64'd0);
        chk("rst_ovf", 64'(bus.Overflow), 64'd0);
        chk("rst_dest", 64'(bus.OutDestVid), 64'd0);
        chk("rst_upd", 64'(bus.OutUpdate), 64'd0);
        rst = 1'b1;

        // Single update into an empty block: one-cycle latency.
        drive(1'b1, 32'h2E, 32'd1, 1'b0, $urandom, $urandom);
        sb_push(32'h2E, 32'd1);
        tick();
        idle();
        chk("lat_valid", 64'(bus.OutValid), 64'd1);
        chk("lat_dest", 64'(bus.OutDestVid), 64'h2E);
        chk("lat_upd", 64'(bus.OutUpdate), 64'd1);
        chk("lat_count", 64'(bus.Count), 64'd1);
        drain("single");

        // Two lanes in one cycle: A then B on consecutive cycles.
        bus.OutReady = 1'b1;
        drive(1'b1, 32'h1F, 32'd1, 1'b1, 32'h1E, 32'd2);
        sb_push(32'h1F, 32'd1);
        sb_push(32'h1E, 32'd2);
        tick();
        idle();
        chk("pair_first_dest", 64'(bus.OutDestVid), 64'h1F);
        tick();
        chk("pair_second_dest", 64'(bus.OutDestVid), 64'h1E);
        drain("pair");

        // Invalid lanes ignored, then lane B alone.
        idle();
        tick();
        chk("idle_count", 64'(bus.Count), 64'd0);
        chk("idle_valid", 64'(bus.OutValid), 64'd0);
        drive(1'b0, $urandom, $urandom, 1'b1, 32'h55, 32'd9);
        sb_push(32'h55, 32'd9);
        tick();
        drain("lane_b");

        // Same destination on both lanes.
        bus.OutReady = 1'b0;
        drive(1'b1, 32'h2E, 32'd1, 1'b1, 32'h2E, 32'd4);
        if (COAL) begin
            sb_push(32'h2E, 32'd5);
        end else begin
            sb_push(32'h2E, 32'd1);
            sb_push(32'h2E, 32'd4);
        end
        tick();
        idle();
        chk("same_dest_count", 64'(bus.Count), COAL ? 64'd1 : 64'd2);
        drain("same_dest");

        // Modulo sum on a coalesced pair.
        drive(1'b1, 32'h2E, 32'hFFFF_FFFF, 1'b1, 32'h2E, 32'd2);
        if (COAL) begin
            sb_push(32'h2E, 32'd1);
        end else begin
            sb_push(32'h2E, 32'hFFFF_FFFF);
            sb_push(32'h2E, 32'd2);
        end
        tick();
        drain("wrap");

        // Merge into the newest stored entry (not the output register).
        bus.OutReady = 1'b0;
        drive(1'b1, 32'h60, 32'd1, 1'b0, $urandom, $urandom);
        tick();
        drive(1'b1, 32'h61, 32'd2, 1'b0, $urandom, $urandom);
        tick();
        drive(1'b1, 32'h61, 32'd3, 1'b0, $urandom, $urandom);
        tick();
        idle();
        sb_push(32'h60, 32'd1);
        if (COAL) begin
            sb_push(32'h61, 32'd5);
        end else begin
            sb_push(32'h61, 32'd2);
            sb_push(32'h61, 32'd3);
        end
        chk("tail_count", 64'(bus.Count), COAL ? 64'd2 : 64'd3);
        drain("tail");

        // Fill to full with two updates per cycle and a stalled output.
        bus.OutReady = 1'b0;
        cnt_m = 0;
        for (int k = 0; k < 10; k++) begin
            acc = (17 - cnt_m) >= 2 ? 2 : (17 - cnt_m);
            drive(1'b1, 32'(32'h100 + 2 * k), 32'(3 * k + 1),
                  1'b1, 32'(32'h101 + 2 * k), 32'(3 * k + 2));
            if (acc >= 1) sb_push(32'(32'h100 + 2 * k), 32'(3 * k + 1));
            if (acc == 2) sb_push(32'(32'h101 + 2 * k), 32'(3 * k + 2));
            cnt_m += acc;
            tick();
            chk("fill_count", 64'(bus.Count), 64'(cnt_m));
            chk("fill_stall", 64'(bus.InStall), 64'((17 - cnt_m) < 2 * (SKID + 1)));
        end
        idle();
        chk("fill_ovf", 64'(bus.Overflow), 64'd1);
        // Push and pop together while full.
        bus.OutReady = 1'b1;
        drive(1'b1, 32'h300, 32'h33, 1'b0, $urandom, $urandom);
        sb_push(32'h300, 32'h33);
        tick();
        idle();
        chk("full_pushpop_count", 64'(bus.Count), 64'd17);
        drain("fill");
        chk("ovf_sticky", 64'(bus.Overflow), 64'd1);
        chk("drained_stall", 64'(bus.InStall), 64'd0);

        // Reset mid-operation with nine entries held.
        bus.OutReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(32'h400 + 2 * k), 32'(k), 1'b1, 32'(32'h401 + 2 * k), 32'(k + 8));
            tick();
        end
        drive(1'b1, 32'h480, 32'd5, 1'b0, $urandom, $urandom);
        tick();
        idle();
        chk("pre_rst_count", 64'(bus.Count), 64'd9);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.OutValid), 64'd0);
        chk("mid_rst_count", 64'(bus.Count), 64'd0);
        chk("mid_rst_stall", 64'(bus.InStall), 64'd0);
        chk("mid_rst_ovf", 64'(bus.Overflow), 64'd0);
        chk("mid_rst_dest", 64'(bus.OutDestVid), 64'd0);
        chk("mid_rst_upd", 64'(bus.OutUpdate), 64'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 32'h10, 32'd7, 1'b0, $urandom, $urandom);
        sb_push(32'h10, 32'd7);
        tick();
        idle();
        chk("post_rst_valid", 64'(bus.OutValid), 64'd1);
        chk("post_rst_dest", 64'(bus.OutDestVid), 64'h10);
        chk("post_rst_upd", 64'(bus.OutUpdate), 64'd7);
        chk("post_rst_count", 64'(bus.Count), 64'd1);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
